// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard unit.
package hazard_pkg;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned FLUSH_CNT_W = 3;
  localparam int unsigned FWD_REGFILE = 0;

  // One in-flight instruction as tracked by the scoreboard.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             load;
  } sb_entry_t;

  // True when an in-flight entry produces the register a decode operand reads.
  // x0 is hardwired to zero, so neither side ever matches on it.
  function automatic logic entry_hits(input sb_entry_t e,
                                      input logic [REG_W-1:0] rs,
                                      input logic rs_used);
    return e.valid && e.we && rs_used && (rs != '0) && (e.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_fwd_match.sv
// Priority forwarding match for one decode operand against the scoreboard.
module hazard_fwd_match
  import hazard_pkg::*;
#(
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned LOAD_LAT  = 2,
  parameter int unsigned SEL_W     = 2
) (
  input  sb_entry_t        entries [FWD_DEPTH],
  input  logic [REG_W-1:0] rs,
  input  logic             rs_used,
  output logic [SEL_W-1:0] sel,
  output logic             load_hazard
);

  logic found;

  // Youngest matching stage wins; flag a load whose data is not yet forwardable.
  always_comb begin
    sel         = SEL_W'(FWD_REGFILE);
    load_hazard = 1'b0;
    found       = 1'b0;
    for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
      if (!found && entry_hits(entries[k], rs, rs_used)) begin
        found       = 1'b1;
        sel         = SEL_W'(k + 1);
        load_hazard = entries[k].load && ((k + 1) < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Decode-stage hazard unit: operand forwarding select, load-use stall,
// redirect flush and a saturating stall-cycle counter.
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned FWD_DEPTH    = 2,
  parameter int unsigned LOAD_LAT     = 2,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned SEL_W        = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic             issue_we,
  input  logic             issue_load,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic             redirect,
  output logic             stall,
  output logic             flush,
  output logic [SEL_W-1:0] fwd_sel_a,
  output logic [SEL_W-1:0] fwd_sel_b,
  output logic [31:0]      stall_cnt
);

  sb_entry_t              sb_q [FWD_DEPTH];
  sb_entry_t              sb_d [FWD_DEPTH];
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [31:0]            stall_cnt_q, stall_cnt_d;

  logic [SEL_W-1:0] sel_a_raw, sel_b_raw;
  logic             haz_a, haz_b;

  hazard_fwd_match #(
    .FWD_DEPTH (FWD_DEPTH),
    .LOAD_LAT  (LOAD_LAT),
    .SEL_W     (SEL_W)
  ) u_match_a (
    .entries     (sb_q),
    .rs          (rs1),
    .rs_used     (rs1_used),
    .sel         (sel_a_raw),
    .load_hazard (haz_a)
  );

  hazard_fwd_match #(
    .FWD_DEPTH (FWD_DEPTH),
    .LOAD_LAT  (LOAD_LAT),
    .SEL_W     (SEL_W)
  ) u_match_b (
    .entries     (sb_q),
    .rs          (rs2),
    .rs_used     (rs2_used),
    .sel         (sel_b_raw),
    .load_hazard (haz_b)
  );

  // Control outputs; rst_n gates redirect so flush stays low throughout reset.
  always_comb begin
    flush     = rst_n && (redirect || (flush_cnt_q != '0));
    stall     = rst_n && !flush && issue_valid && (haz_a || haz_b);
    fwd_sel_a = rst_n ? sel_a_raw : SEL_W'(FWD_REGFILE);
    fwd_sel_b = rst_n ? sel_b_raw : SEL_W'(FWD_REGFILE);
    stall_cnt = stall_cnt_q;
  end

  // Next state: scoreboard shift, flush down-counter, saturating stall count.
  always_comb begin
    for (int unsigned k = 1; k < FWD_DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
    sb_d[0] = '0;
    if (issue_valid && !stall && !flush) begin
      sb_d[0].valid = 1'b1;
      sb_d[0].rd    = issue_rd;
      sb_d[0].we    = issue_we;
      sb_d[0].load  = issue_load;
    end

    // Redirect cycle is itself the first flush cycle, so reload with one less.
    flush_cnt_d = flush_cnt_q;
    if (redirect) begin
      flush_cnt_d = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    end else if (flush_cnt_q != '0) begin
      flush_cnt_d = flush_cnt_q - 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
        sb_q[k] <= '0;
      end
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
        sb_q[k] <= sb_d[k];
      end
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Self-checking bench for pipeline_hazard_unit with a behavioural model.
module tb_pipeline_hazard_unit;

  localparam int unsigned DEPTH = 3;
  localparam int unsigned LLAT  = 2;
  localparam int unsigned FCYC  = 2;
  localparam int unsigned SW    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue_valid, issue_we, issue_load;
  logic [4:0]    issue_rd, rs1, rs2;
  logic          rs1_used, rs2_used, redirect;
  logic          stall, flush;
  logic [SW-1:0] fwd_sel_a, fwd_sel_b;
  logic [31:0]   stall_cnt;

  int checks = 0;
  int errors = 0;

  // Model: list of instructions issued in recent cycles, youngest first.
  typedef struct {
    bit          v;
    int unsigned rd;
    bit          we;
    bit          ld;
  } rec_t;

  rec_t        hist[$];
  int unsigned since_redirect;
  longint unsigned m_stall_cnt;

  pipeline_hazard_unit #(
    .FWD_DEPTH    (DEPTH),
    .LOAD_LAT     (LLAT),
    .FLUSH_CYCLES (FCYC),
    .SEL_W        (SW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_we    (issue_we),
    .issue_load  (issue_load),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_used    (rs1_used),
    .rs2_used    (rs2_used),
    .redirect    (redirect),
    .stall       (stall),
    .flush       (flush),
    .fwd_sel_a   (fwd_sel_a),
    .fwd_sel_b   (fwd_sel_b),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Index of the youngest in-flight producer of rs, or -1 when none.
  function automatic int m_idx(input int unsigned rs, input bit used);
    for (int i = 0; i < hist.size(); i++) begin
      if (used && rs != 0 && hist[i].v && hist[i].we && hist[i].rd == rs) return i;
    end
    return -1;
  endfunction

  function automatic bit m_load_wait(input int idx);
    return (idx >= 0) && hist[idx].ld && ((idx + 1) < LLAT);
  endfunction

  task automatic model_reset();
    hist.delete();
    since_redirect = 1000;
    m_stall_cnt    = 0;
  endtask

  // One clock cycle: called at posedge+1, drives inputs, checks mid-cycle,
  // advances the model across the next edge and checks the counter.
  task automatic step(input bit iv, input int unsigned rd, input bit we, input bit ld,
                      input int unsigned a, input bit au, input int unsigned b,
                      input bit bu, input bit rdr, input string tag);
    int ia, ib;
    bit f, s;
    rec_t r;
    issue_valid = iv;
    issue_rd    = 5'(rd);
    issue_we    = we;
    issue_load  = ld;
    rs1         = 5'(a);
    rs1_used    = au;
    rs2         = 5'(b);
    rs2_used    = bu;
    redirect    = rdr;
    #3;
    ia = m_idx(a, au);
    ib = m_idx(b, bu);
    f  = rdr || (since_redirect < FCYC);
    s  = iv && !f && (m_load_wait(ia) || m_load_wait(ib));
    check({tag, "_sel_a"}, 32'(fwd_sel_a), 32'(ia + 1));
    check({tag, "_sel_b"}, 32'(fwd_sel_b), 32'(ib + 1));
    check({tag, "_stall"}, 32'(stall), 32'(s));
    check({tag, "_flush"}, 32'(flush), 32'(f));
    @(posedge clk);
    #1;
    if (iv && !s && !f) begin
      r = '{v: 1'b1, rd: rd, we: we, ld: ld};
    end else begin
      r = '{v: 1'b0, rd: 0, we: 1'b0, ld: 1'b0};
    end
    hist.push_front(r);
    if (hist.size() > DEPTH) void'(hist.pop_back());
    if (rdr) since_redirect = 1;
    else if (since_redirect < 1000) since_redirect++;
    if (s && m_stall_cnt != 64'hFFFF_FFFF) m_stall_cnt++;
    check({tag, "_stall_cnt"}, stall_cnt, 32'(m_stall_cnt));
  endtask

  // Called mid-cycle: assert reset, check outputs idle, release off-edge.
  task automatic reset_abort(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_flush"}, 32'(flush), 32'd0);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_sel_a"}, 32'(fwd_sel_a), 32'd0);
    check({tag, "_sel_b"}, 32'(fwd_sel_b), 32'd0);
    check({tag, "_cnt"}, stall_cnt, 32'd0);
    @(posedge clk);
    #2;
    issue_valid = 1'b0;
    redirect    = 1'b0;
    rst_n       = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    issue_we    = 1'b0;
    issue_load  = 1'b0;
    rs1         = 5'd1;
    rs2         = 5'd2;
    rs1_used    = 1'b1;
    rs2_used    = 1'b1;
    redirect    = 1'b1;
    model_reset();
    #2;
    check("reset_flush", 32'(flush), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_sel_a", 32'(fwd_sel_a), 32'd0);
    check("reset_sel_b", 32'(fwd_sel_b), 32'd0);
    check("reset_cnt", stall_cnt, 32'd0);
    #10;
    redirect = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;

    // Forward from stage 0: addi x3,x2,1 then addi x6,x3,0.
    step(1, 3, 1, 0, 2, 1, 0, 0, 0, "fwd0_prod");
    step(1, 6, 1, 0, 3, 1, 0, 0, 0, "fwd0_use");
    check("fwd0_sel_a_const", 32'(hist[1].rd), 32'd3);

    // Forward from stage 1: addi x3, bubble, add x6,x3,x3.
    step(1, 3, 1, 0, 2, 1, 0, 0, 0, "fwd1_prod");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "fwd1_gap");
    step(1, 6, 1, 0, 3, 1, 3, 1, 0, "fwd1_use");

    // Load-use: lw x3 then addi x5,x3,5 stalls once, then forwards from stage 1.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "lu_drain0");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "lu_drain1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "lu_drain2");
    step(1, 3, 1, 1, 2, 1, 0, 0, 0, "lu_load");
    step(1, 5, 1, 0, 3, 1, 0, 0, 0, "lu_stall");
    step(1, 5, 1, 0, 3, 1, 0, 0, 0, "lu_resume");
    check("lu_cnt_abs", stall_cnt, 32'd1);

    // Redirect with a load-use hazard present: flush wins, in-flight load drains.
    step(1, 7, 1, 1, 0, 0, 0, 0, 0, "rd_load");
    step(1, 8, 1, 0, 7, 1, 0, 0, 1, "rd_flush0");
    step(1, 8, 1, 0, 7, 1, 0, 0, 0, "rd_flush1");
    step(1, 8, 1, 0, 7, 1, 0, 0, 0, "rd_after");
    // Back-to-back redirect reloads the counter.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, "rr_a");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, "rr_b");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "rr_c");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "rr_d");

    // x0 never matches, even for a load writing x0.
    step(1, 0, 1, 1, 0, 1, 0, 1, 0, "x0_prod");
    step(1, 4, 1, 0, 0, 1, 0, 1, 0, "x0_use");

    // Reset in the middle of a flush.
    issue_valid = 1'b0;
    redirect    = 1'b1;
    #3;
    check("rst_flush_pre", 32'(flush), 32'd1);
    reset_abort("rst_mid_flush");
    step(1, 9, 1, 0, 3, 1, 7, 1, 0, "rst_indep");

    // Reset in the middle of a load-use stall.
    step(1, 4, 1, 1, 0, 0, 0, 0, 0, "rsts_load");
    issue_valid = 1'b1;
    issue_rd    = 5'd5;
    issue_load  = 1'b0;
    rs1         = 5'd4;
    rs1_used    = 1'b1;
    rs2_used    = 1'b0;
    redirect    = 1'b0;
    #3;
    check("rsts_stall_pre", 32'(stall), 32'd1);
    reset_abort("rst_mid_stall");
    step(1, 6, 1, 0, 4, 1, 0, 0, 0, "rsts_indep");

    // Randomised traffic over a small register set to provoke many matches.
    for (int n = 0; n < 400; n++) begin
      step(bit'($urandom_range(0, 3) != 0), $urandom_range(0, 3), bit'($urandom_range(0, 4) != 0),
           bit'($urandom_range(0, 2) == 0), $urandom_range(0, 3), bit'($urandom_range(0, 3) != 0),
           $urandom_range(0, 3), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 9) == 0), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
